multicycle_control: RTL and testbench

MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

---
 rtl/multicycle_control.sv | 196 +++++++++++++++++++
 tb/tb_multicycle_control.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_control.sv
// Multicycle processor control unit: a two-process FSM that sequences
// fetch, decode, execute, memory and write-back. It drives the datapath
// strobes and tracks how many instructions have retired.
module multicycle_control (
  input  logic        clk,
  input  logic        reset,
  input  logic [5:0]  opcode_i,
  input  logic        zero_i,
  input  logic        mem_ready_i,
  output logic        pc_write_o,
  output logic        ir_write_o,
  output logic        mem_read_o,
  output logic        mem_write_o,
  output logic        reg_write_o,
  output logic [1:0]  pc_src_o,
  output logic [1:0]  wb_sel_o,
  output logic [3:0]  alu_op_o,
  output logic        illegal_op_o,
  output logic        instr_done_o,
  output logic [15:0] retired_count_o,
  output logic [2:0]  state_o
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_TRAP   = 3'd7
  } state_t;

  // Instruction classes latched in DECODE; they double as the ALU op code.
  localparam logic [3:0] C_RTYPE = 4'b1111;
  localparam logic [3:0] C_ADDI  = 4'b0000;
  localparam logic [3:0] C_ORI   = 4'b0001;
  localparam logic [3:0] C_LUI   = 4'b0010;
  localparam logic [3:0] C_ANDI  = 4'b0011;
  localparam logic [3:0] C_LW    = 4'b0100;
  localparam logic [3:0] C_SW    = 4'b0101;
  localparam logic [3:0] C_BEQ   = 4'b0110;
  localparam logic [3:0] C_BNE   = 4'b0111;
  localparam logic [3:0] C_J     = 4'b1000;
  localparam logic [3:0] C_JAL   = 4'b1001;

  localparam logic [1:0] PC_PLUS4  = 2'b00;
  localparam logic [1:0] PC_BRANCH = 2'b01;
  localparam logic [1:0] PC_JUMP   = 2'b10;

  localparam logic [1:0] WB_ALU  = 2'b00;
  localparam logic [1:0] WB_MEM  = 2'b01;
  localparam logic [1:0] WB_LINK = 2'b10;

  state_t      state_q, state_d;
  logic [3:0]  cls_q, cls_d;
  logic [1:0]  wb_sel_q, wb_sel_d;
  logic        illegal_q, illegal_d;
  logic [15:0] retired_q, retired_d;
  logic [4:0]  dec;

  // Maps an opcode to {supported, class}; an unsupported opcode yields 0 in bit 4.
  function automatic logic [4:0] decode_op(input logic [5:0] op);
    logic [4:0] r;
    r = 5'b0_0000;
    case (op)
      6'b000000: r = {1'b1, C_RTYPE};
      6'b001000: r = {1'b1, C_ADDI};
      6'b001101: r = {1'b1, C_ORI};
      6'b001111: r = {1'b1, C_LUI};
      6'b001100: r = {1'b1, C_ANDI};
      6'b100011: r = {1'b1, C_LW};
      6'b101011: r = {1'b1, C_SW};
      6'b000100: r = {1'b1, C_BEQ};
      6'b000101: r = {1'b1, C_BNE};
      6'b000010: r = {1'b1, C_J};
      6'b000011: r = {1'b1, C_JAL};
      default:   r = 5'b0_0000;
    endcase
    return r;
  endfunction

  // Next-state, datapath strobes and retirement pulse for the current state.
  always_comb begin
    state_d      = state_q;
    cls_d        = cls_q;
    wb_sel_d     = wb_sel_q;
    illegal_d    = illegal_q;
    pc_write_o   = 1'b0;
    ir_write_o   = 1'b0;
    mem_read_o   = 1'b0;
    mem_write_o  = 1'b0;
    reg_write_o  = 1'b0;
    pc_src_o     = PC_PLUS4;
    alu_op_o     = 4'b0000;
    dec          = decode_op(opcode_i);

    case (state_q)
      S_FETCH: begin
        mem_read_o = 1'b1;
        if (mem_ready_i) begin
          ir_write_o = 1'b1;
          pc_write_o = 1'b1;
          state_d    = S_DECODE;
        end
      end
      S_DECODE: begin
        if (dec[4]) begin
          cls_d   = dec[3:0];
          state_d = S_EXEC;
        end else begin
          illegal_d = 1'b1;
          state_d   = S_TRAP;
        end
      end
      S_EXEC: begin
        alu_op_o = cls_q;
        case (cls_q)
          C_RTYPE, C_ADDI, C_ORI, C_LUI, C_ANDI: begin
            wb_sel_d = WB_ALU;
            state_d  = S_WB;
          end
          C_LW, C_SW: state_d = S_MEM;
          C_BEQ, C_BNE: begin
            // bne takes the branch on the inverted zero condition.
            if (zero_i ^ (cls_q == C_BNE)) begin
              pc_write_o = 1'b1;
              pc_src_o   = PC_BRANCH;
            end
            state_d = S_FETCH;
          end
          C_J: begin
            pc_write_o = 1'b1;
            pc_src_o   = PC_JUMP;
            state_d    = S_FETCH;
          end
          C_JAL: begin
            pc_write_o = 1'b1;
            pc_src_o   = PC_JUMP;
            wb_sel_d   = WB_LINK;
            state_d    = S_WB;
          end
          default: begin
            illegal_d = 1'b1;
            state_d   = S_TRAP;
          end
        endcase
      end
      S_MEM: begin
        if (cls_q == C_SW) mem_write_o = 1'b1;
        else               mem_read_o  = 1'b1;
        if (mem_ready_i) begin
          if (cls_q == C_SW) begin
            state_d = S_FETCH;
          end else begin
            wb_sel_d = WB_MEM;
            state_d  = S_WB;
          end
        end
      end
      S_WB: begin
        reg_write_o = 1'b1;
        state_d     = S_FETCH;
      end
      S_TRAP: state_d = S_TRAP;
      default: state_d = S_FETCH;
    endcase

    // A reset cycle abandons the instruction, so it never counts as a retirement.
    instr_done_o = !reset && (state_d == S_FETCH) &&
                   ((state_q == S_EXEC) || (state_q == S_MEM) || (state_q == S_WB));
    retired_d    = retired_q + {15'd0, instr_done_o};
  end

  // State and bookkeeping registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_FETCH;
      cls_q     <= 4'b0000;
      wb_sel_q  <= WB_ALU;
      illegal_q <= 1'b0;
      retired_q <= 16'd0;
    end else begin
      state_q   <= state_d;
      cls_q     <= cls_d;
      wb_sel_q  <= wb_sel_d;
      illegal_q <= illegal_d;
      retired_q <= retired_d;
    end
  end

  assign wb_sel_o        = wb_sel_q;
  assign illegal_op_o    = illegal_q;
  assign retired_count_o = retired_q;
  assign state_o         = state_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Testbench for multicycle_control: builds an expected per-cycle trace
// for each directed instruction, queues it, then replays it cycle by cycle.
module tb_multicycle_control;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [5:0]  opcode_i = 6'd0;
  logic        zero_i = 1'b0;
  logic        mem_ready_i = 1'b0;
  logic        pc_write_o, ir_write_o, mem_read_o, mem_write_o, reg_write_o;
  logic [1:0]  pc_src_o, wb_sel_o;
  logic [3:0]  alu_op_o;
  logic        illegal_op_o, instr_done_o;
  logic [15:0] retired_count_o;
  logic [2:0]  state_o;

  multicycle_control dut (
    .clk(clk), .reset(reset), .opcode_i(opcode_i), .zero_i(zero_i),
    .mem_ready_i(mem_ready_i), .pc_write_o(pc_write_o), .ir_write_o(ir_write_o),
    .mem_read_o(mem_read_o), .mem_write_o(mem_write_o), .reg_write_o(reg_write_o),
    .pc_src_o(pc_src_o), .wb_sel_o(wb_sel_o), .alu_op_o(alu_op_o),
    .illegal_op_o(illegal_op_o), .instr_done_o(instr_done_o),
    .retired_count_o(retired_count_o), .state_o(state_o)
  );

  always #5 clk = ~clk;

  // Expected output vector layout:
  // {state, mem_read, mem_write, ir_write, pc_write, reg_write, pc_src, wb_sel, alu_op, illegal, done, count}
  typedef struct {
    logic        rst;
    logic        rdy;
    logic        zero;
    logic [5:0]  op;
    bit          full;
    logic [33:0] exp;
    string       tag;
  } step_t;

  step_t       sb[$];
  int          compared = 0;
  int          mismatched = 0;
  int          cyc = 0;
  logic [15:0] exp_cnt = 16'd0;
  logic [1:0]  exp_wb = 2'b00;
  logic        exp_ill = 1'b0;

  function automatic logic [4:0] cls_of(input logic [5:0] op);
    case (op)
      6'b000000: return 5'h1F;
      6'b001000: return 5'h10;
      6'b001101: return 5'h11;
      6'b001111: return 5'h12;
      6'b001100: return 5'h13;
      6'b100011: return 5'h14;
      6'b101011: return 5'h15;
      6'b000100: return 5'h16;
      6'b000101: return 5'h17;
      6'b000010: return 5'h18;
      6'b000011: return 5'h19;
      default:   return 5'h00;
    endcase
  endfunction

  task automatic push(input logic r, input logic rd, input logic z, input logic [5:0] op,
                      input bit full, input string tag, input logic [2:0] st,
                      input logic mr, input logic mw, input logic ir, input logic pcw,
                      input logic rw, input logic [1:0] pcs, input logic [3:0] alu,
                      input logic done);
    step_t s;
    s.rst = r; s.rdy = rd; s.zero = z; s.op = op; s.full = full; s.tag = tag;
    s.exp = {st, mr, mw, ir, pcw, rw, pcs, exp_wb, alu, exp_ill, done, exp_cnt};
    sb.push_back(s);
    if (done) exp_cnt = exp_cnt + 16'd1;
  endtask

  task automatic add_reset(input int n);
    for (int i = 0; i < n; i++)
      push(1'b1, 1'b0, 1'b0, 6'd0, 1'b0, "reset", 3'd0, 0, 0, 0, 0, 0, 2'b00, 4'h0, 1'b0);
    exp_cnt = 16'd0; exp_wb = 2'b00; exp_ill = 1'b0;
  endtask

  task automatic add_idle_fetch(input string tag);
    push(1'b0, 1'b0, 1'b0, 6'd0, 1'b1, tag, 3'd0, 1, 0, 0, 0, 0, 2'b00, 4'h0, 1'b0);
  endtask

  task automatic add_trap(input int n);
    for (int i = 0; i < n; i++)
      push(1'b0, 1'b1, 1'b0, 6'h3F, 1'b1, "trap", 3'd7, 0, 0, 0, 0, 0, 2'b00, 4'h0, 1'b0);
  endtask

  task automatic add_instr(input string nm, input logic [5:0] op, input logic z,
                           input int fwait, input int mwait);
    logic [4:0] c;
    logic       tk;
    c = cls_of(op);
    for (int i = 0; i < fwait; i++)
      push(0, 0, z, op, 1, {nm, ".fetchwait"}, 3'd0, 1, 0, 0, 0, 0, 2'b00, 4'h0, 0);
    push(0, 1, z, op, 1, {nm, ".fetch"}, 3'd0, 1, 0, 1, 1, 0, 2'b00, 4'h0, 0);
    push(0, 1, z, op, 1, {nm, ".decode"}, 3'd1, 0, 0, 0, 0, 0, 2'b00, 4'h0, 0);
    if (!c[4]) begin
      exp_ill = 1'b1;
      return;
    end
    case (c[3:0])
      4'b0100, 4'b0101: begin
        push(0, 1, z, op, 1, {nm, ".exec"}, 3'd2, 0, 0, 0, 0, 0, 2'b00, c[3:0], 0);
        for (int i = 0; i < mwait; i++)
          push(0, 0, z, op, 1, {nm, ".memwait"}, 3'd3, !c[0], c[0], 0, 0, 0, 2'b00, 4'h0, 0);
        push(0, 1, z, op, 1, {nm, ".mem"}, 3'd3, !c[0], c[0], 0, 0, 0, 2'b00, 4'h0, c[0]);
        if (!c[0]) begin
          exp_wb = 2'b01;
          push(0, 1, z, op, 1, {nm, ".wb"}, 3'd4, 0, 0, 0, 0, 1, 2'b00, 4'h0, 1);
        end
      end
      4'b0110, 4'b0111: begin
        tk = (c[3:0] == 4'b0110) ? z : !z;
        push(0, 1, z, op, 1, {nm, ".exec"}, 3'd2, 0, 0, 0, tk, 0, tk ? 2'b01 : 2'b00, c[3:0], 1);
      end
      4'b1000:
        push(0, 1, z, op, 1, {nm, ".exec"}, 3'd2, 0, 0, 0, 1, 0, 2'b10, c[3:0], 1);
      4'b1001: begin
        push(0, 1, z, op, 1, {nm, ".exec"}, 3'd2, 0, 0, 0, 1, 0, 2'b10, c[3:0], 0);
        exp_wb = 2'b10;
        push(0, 1, z, op, 1, {nm, ".wb"}, 3'd4, 0, 0, 0, 0, 1, 2'b00, 4'h0, 1);
      end
      default: begin
        push(0, 1, z, op, 1, {nm, ".exec"}, 3'd2, 0, 0, 0, 0, 0, 2'b00, c[3:0], 0);
        exp_wb = 2'b00;
        push(0, 1, z, op, 1, {nm, ".wb"}, 3'd4, 0, 0, 0, 0, 1, 2'b00, 4'h0, 1);
      end
    endcase
  endtask

  // Replays queued steps: drive on the falling edge, compare 1 time unit later.
  task automatic run();
    step_t       s;
    logic [33:0] obs;
    while (sb.size() > 0) begin
      s = sb.pop_front();
      @(negedge clk);
      reset = s.rst; mem_ready_i = s.rdy; zero_i = s.zero; opcode_i = s.op;
      #1;
      cyc++;
      obs = {state_o, mem_read_o, mem_write_o, ir_write_o, pc_write_o, reg_write_o,
             pc_src_o, wb_sel_o, alu_op_o, illegal_op_o, instr_done_o, retired_count_o};
      compared++;
      if (s.full) begin
        assert (obs === s.exp) else begin
          mismatched++;
          $error("FAIL %s cyc%0d: observed %h expected %h", s.tag, cyc, obs, s.exp);
        end
      end else begin
        assert (instr_done_o === 1'b0) else begin
          mismatched++;
          $error("FAIL %s cyc%0d done: observed %b expected 0", s.tag, cyc, instr_done_o);
        end
      end
    end
  endtask

  initial begin
    add_reset(2);
    add_idle_fetch("post_reset");
    add_instr("add", 6'b000000, 1'b0, 0, 0);
    add_instr("addi", 6'b001000, 1'b0, 1, 0);
    add_instr("ori", 6'b001101, 1'b1, 0, 0);
    add_instr("lui", 6'b001111, 1'b0, 2, 0);
    add_instr("andi", 6'b001100, 1'b0, 0, 0);
    add_instr("lw", 6'b100011, 1'b0, 0, 3);
    add_instr("sw", 6'b101011, 1'b0, 0, 1);
    add_instr("beq_t", 6'b000100, 1'b1, 0, 0);
    add_instr("bne_nt", 6'b000101, 1'b1, 0, 0);
    add_instr("beq_nt", 6'b000100, 1'b0, 0, 0);
    add_instr("bne_t", 6'b000101, 1'b0, 0, 0);
    add_instr("j", 6'b000010, 1'b0, 0, 0);
    add_instr("jal", 6'b000011, 1'b0, 0, 0);
    add_instr("add2", 6'b000000, 1'b0, 0, 0);
    run();

    // Preload the retirement counter just below wrap.
    @(posedge clk);
    #1 force dut.retired_q = 16'hFFFF;
    #1 release dut.retired_q;
    exp_cnt = 16'hFFFF;
    add_instr("j_wrap", 6'b000010, 1'b0, 0, 0);
    add_instr("add_after_wrap", 6'b000000, 1'b0, 0, 0);
    run();

    // Unsupported opcode traps until reset.
    add_instr("illegal", 6'h3F, 1'b0, 0, 0);
    add_trap(20);
    add_reset(1);
    add_idle_fetch("post_trap_reset");
    add_instr("add3", 6'b000000, 1'b0, 0, 0);
    run();

    // Reset in the MEM cycle of a store abandons it.
    add_instr("addi2", 6'b001000, 1'b0, 0, 0);
    push(0, 1, 0, 6'b101011, 1, "sw_rst.fetch", 3'd0, 1, 0, 1, 1, 0, 2'b00, 4'h0, 0);
    push(0, 1, 0, 6'b101011, 1, "sw_rst.decode", 3'd1, 0, 0, 0, 0, 0, 2'b00, 4'h0, 0);
    push(0, 1, 0, 6'b101011, 1, "sw_rst.exec", 3'd2, 0, 0, 0, 0, 0, 2'b00, 4'h5, 0);
    push(0, 0, 0, 6'b101011, 1, "sw_rst.mem", 3'd3, 0, 1, 0, 0, 0, 2'b00, 4'h0, 0);
    push(1, 1, 0, 6'b101011, 0, "sw_rst.reset", 3'd0, 0, 0, 0, 0, 0, 2'b00, 4'h0, 0);
    exp_cnt = 16'd0; exp_wb = 2'b00; exp_ill = 1'b0;
    add_idle_fetch("sw_rst.after");
    add_instr("lw_final", 6'b100011, 1'b0, 1, 0);
    run();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
